// File: rtl/io_rx_stream_writer.sv
// io_rx_stream_writer
// Streaming image loader: accepts pixel beats over a valid/ready handshake
// and writes each one into the image SRAM in raster order, channel fastest.
// A frame is started with start (dimensions latched at that moment),
// cancelled with abort, and completion is signalled by a one-cycle done.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   start, abort        frame control (abort wins over start)
//   nrows, ncols        last row / column index of the frame
//   s_valid, s_data     input stream beat
//   s_ready             writer accepts a beat this cycle
//   busy                frame in progress
//   done                one-cycle pulse alongside the final SRAM write
//   overflow            sticky: a beat was offered while idle and dropped
//   sram_*              image SRAM write port (one cycle after accept)
module io_rx_stream_writer #(
    parameter int DATA_W = 8,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 8,
    parameter int NCH    = 1,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [ROW_W-1:0]  nrows,
    input  logic [COL_W-1:0]  ncols,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              sram_sense_en,
    output logic              sram_we,
    output logic [ROW_W-1:0]  sram_row,
    output logic [COL_W-1:0]  sram_col,
    output logic [CH_W-1:0]   sram_ch,
    output logic [DATA_W-1:0] sram_din
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

    state_t              state_r;
    state_t              state_s;
    logic [ROW_W-1:0]    nrows_r;
    logic [COL_W-1:0]    ncols_r;
    logic [ROW_W-1:0]    row_r;
    logic [COL_W-1:0]    col_r;
    logic [CH_W-1:0]     ch_r;
    logic                s_ready_r;
    logic                busy_r;
    logic                done_r;
    logic                overflow_r;
    logic                we_r;
    logic [ROW_W-1:0]    wrow_r;
    logic [COL_W-1:0]    wcol_r;
    logic [CH_W-1:0]     wch_r;
    logic [DATA_W-1:0]   wdin_r;
    logic                accept_s;
    logic                final_s;
    logic                launch_s;

    // Handshake decode and next-state selection.
    always_comb begin
        accept_s = s_valid && s_ready_r;
        final_s  = accept_s && (ch_r == CH_LAST) && (col_r == ncols_r) && (row_r == nrows_r);
        launch_s = (state_r == ST_IDLE) && start && !abort;
        state_s  = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (final_s) begin
                    state_s = ST_LAST;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_LAST: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and status outputs, registered from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            s_ready_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            s_ready_r <= (state_s == ST_RUN);
            busy_r    <= (state_s != ST_IDLE);
            // An aborted final beat is still written but never reported as done.
            done_r    <= final_s && !abort;
            if (launch_s) begin
                overflow_r <= 1'b0;
            end else if ((state_r == ST_IDLE) && s_valid) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Frame dimension latch and raster address counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nrows_r <= '0;
            ncols_r <= '0;
            row_r   <= '0;
            col_r   <= '0;
            ch_r    <= '0;
        end else if (abort) begin
            row_r <= '0;
            col_r <= '0;
            ch_r  <= '0;
        end else if (launch_s) begin
            nrows_r <= nrows;
            ncols_r <= ncols;
            row_r   <= '0;
            col_r   <= '0;
            ch_r    <= '0;
        end else if (accept_s) begin
            // Equality on last indices lets full-range dimensions wrap cleanly.
            if (ch_r == CH_LAST) begin
                ch_r <= '0;
                if (col_r == ncols_r) begin
                    col_r <= '0;
                    row_r <= row_r + ROW_W'(1);
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end else begin
                ch_r <= ch_r + CH_W'(1);
            end
        end
    end

    // Write stage: an accepted beat is presented to the SRAM for exactly one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_r   <= 1'b0;
            wrow_r <= '0;
            wcol_r <= '0;
            wch_r  <= '0;
            wdin_r <= '0;
        end else begin
            we_r <= accept_s;
            if (accept_s) begin
                wrow_r <= row_r;
                wcol_r <= col_r;
                wch_r  <= ch_r;
                wdin_r <= s_data;
            end
        end
    end

    assign s_ready       = s_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign overflow      = overflow_r;
    assign sram_sense_en = 1'b1;
    assign sram_we       = we_r;
    assign sram_row      = wrow_r;
    assign sram_col      = wcol_r;
    assign sram_ch       = wch_r;
    assign sram_din      = wdin_r;

endmodule
